// File: rtl/mem_copy_engine_if.sv
// Control and memory-bus bundle for mem_copy_engine. The fill_i/fill_data_i pair
// exists only when MEMCOPY_FILL_EN is defined.
interface mem_copy_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 16
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] src_addr_i;
  logic [ADDR_WIDTH-1:0] dst_addr_i;
  logic [ADDR_WIDTH-1:0] len_i;
`ifdef MEMCOPY_FILL_EN
  logic                  fill_i;
  logic [LINE_WIDTH-1:0] fill_data_i;
`endif
  logic                  busy_o;
  logic                  done_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [LINE_WIDTH-1:0] mem_rd_data_i;
  logic [LINE_WIDTH-1:0] mem_wr_data_o;
  logic                  mem_we_o;

  modport slave (
    input  start_i, src_addr_i, dst_addr_i, len_i,
`ifdef MEMCOPY_FILL_EN
    input  fill_i, fill_data_i,
`endif
    input  mem_rd_data_i,
    output busy_o, done_o, mem_addr_o, mem_wr_data_o, mem_we_o
  );

  modport master (
    output start_i, src_addr_i, dst_addr_i, len_i,
`ifdef MEMCOPY_FILL_EN
    output fill_i, fill_data_i,
`endif
    output mem_rd_data_i,
    input  busy_o, done_o, mem_addr_o, mem_wr_data_o, mem_we_o
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Line-by-line memory copy engine (READ/WRITE per line, ascending addresses).
// Defining MEMCOPY_FILL_EN adds a fill mode that writes a constant pattern and skips READ.
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  mem_copy_engine_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH-1:0] r_rem;
  logic [LINE_WIDTH-1:0] r_data;
  logic                  r_fill;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wr_data;

  logic                  w_fill_req;
  logic [LINE_WIDTH-1:0] w_fill_data;

`ifdef MEMCOPY_FILL_EN
  assign w_fill_req  = bus.fill_i;
  assign w_fill_data = bus.fill_data_i;
`else
  assign w_fill_req  = 1'b0;
  assign w_fill_data = '0;
`endif

  // Outputs are loaded alongside the state they belong to, so every output is a
  // flop and reflects the current state exactly (Moore behaviour).
  // NOTE: all state here uses non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_data    <= '0;
      r_fill    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.len_i != '0) begin
              r_src  <= bus.src_addr_i;
              r_dst  <= bus.dst_addr_i;
              r_rem  <= bus.len_i;
              r_fill <= w_fill_req;
              r_busy <= 1'b1;
              if (w_fill_req) begin
                r_state   <= S_WRITE;
                r_data    <= w_fill_data;
                r_wr_data <= w_fill_data;
                r_addr    <= bus.dst_addr_i;
                r_we      <= 1'b1;
              end else begin
                r_state <= S_READ;
                r_addr  <= bus.src_addr_i;
              end
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_READ: begin
          r_state   <= S_WRITE;
          r_data    <= bus.mem_rd_data_i;
          r_wr_data <= bus.mem_rd_data_i;
          r_addr    <= r_dst;
          r_we      <= 1'b1;
        end

        S_WRITE: begin
          r_src <= r_src + ONE;
          r_dst <= r_dst + ONE;
          r_rem <= r_rem - ONE;
          if (r_rem == ONE) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
          end else if (r_fill) begin
            r_addr <= r_dst + ONE;
          end else begin
            r_state   <= S_READ;
            r_we      <= 1'b0;
            r_addr    <= r_src + ONE;
            r_wr_data <= '0;
          end
        end

        S_DONE: begin
          // start_i is deliberately not sampled here; a new request waits for IDLE.
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_addr    <= '0;
          r_wr_data <= '0;
          r_we      <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.mem_we_o      = r_we;
  assign bus.mem_addr_o    = r_addr;
  assign bus.mem_wr_data_o = r_wr_data;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a line-level reference model predicts reads,
// writes and the done cycle; a negedge monitor compares them. Honours MEMCOPY_FILL_EN.
module tb_mem_copy_engine;

  localparam int AW = 16;
  localparam int LW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [LW-1:0] mem       [0:(1<<AW)-1];
  logic [LW-1:0] model_mem [0:(1<<AW)-1];

  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  int            dq[$];

  mem_copy_engine_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  mem_copy_engine #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rd_data_i = mem[bus.mem_addr_o];
  always @(posedge clk) if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wr_data_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each line i of the operation moves mem[src+i] (or the fill pattern)
  // to dst+i, in ascending order, with addresses wrapping at 16 bits.
  task automatic model_op(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input logic [AW-1:0] len, input bit fill, input logic [LW-1:0] fdata,
                          input int nlines, input int acc, input bit with_done);
    for (int i = 0; i < nlines; i++) begin
      logic [AW-1:0] r;
      logic [AW-1:0] w;
      logic [LW-1:0] d;
      wr_t e;
      r = src + AW'(i);
      w = dst + AW'(i);
      d = fill ? fdata : model_mem[r];
      if (!fill) rq.push_back(r);
      model_mem[w] = d;
      e.addr = w;
      e.data = d;
      wq.push_back(e);
    end
    if (with_done) dq.push_back(acc + (fill ? int'(len) : 2 * int'(len)));
  endtask

  always @(negedge clk) begin
    wr_t           e;
    logic [AW-1:0] ra;
    int            dc;
    if (bus.mem_we_o) begin
      if (wq.size() == 0) check("unexpected_write", {bus.mem_addr_o, bus.mem_wr_data_o}, 64'h0);
      else begin
        e = wq.pop_front();
        check("wr_addr", bus.mem_addr_o, e.addr);
        check("wr_data", bus.mem_wr_data_o, e.data);
      end
      check("busy_in_write", bus.busy_o, 1'b1);
    end else if (bus.busy_o) begin
      if (rq.size() == 0) check("unexpected_read", bus.mem_addr_o, 64'h0);
      else begin
        ra = rq.pop_front();
        check("rd_addr", bus.mem_addr_o, ra);
      end
    end else if (!bus.done_o) begin
      check("idle_outs", {bus.mem_addr_o, bus.mem_wr_data_o}, 64'h0);
    end
    if (bus.done_o) begin
      check("done_not_busy", {bus.busy_o, bus.mem_we_o}, 64'h0);
      if (dq.size() == 0) check("unexpected_done", 1'b1, 1'b0);
      else begin
        dc = dq.pop_front();
        check("done_cycle", cyc, dc);
      end
    end
  end

  task automatic drain(input string name);
    check({name, "_drain"}, {wq.size(), rq.size(), dq.size()}, 64'h0);
    wq.delete(); rq.delete(); dq.delete();
  endtask

  task automatic run_op(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                        input logic [AW-1:0] len, input bit fill, input logic [LW-1:0] fdata,
                        input string name);
    int acc;
    bus.src_addr_i = src;
    bus.dst_addr_i = dst;
    bus.len_i      = len;
`ifdef MEMCOPY_FILL_EN
    bus.fill_i      = fill;
    bus.fill_data_i = fdata;
`endif
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    bus.start_i = 1'b0;
    model_op(src, dst, len, fill, fdata, int'(len), acc, 1'b1);
    repeat (2 * int'(len) + 4) @(posedge clk);
    #1;
    drain(name);
  endtask

  initial begin
    int acc;
    int mism;
    bus.start_i = 1'b0;
    bus.src_addr_i = '0;
    bus.dst_addr_i = '0;
    bus.len_i = '0;
`ifdef MEMCOPY_FILL_EN
    bus.fill_i = 1'b0;
    bus.fill_data_i = '0;
`endif
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = LW'($urandom);
      model_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {bus.busy_o, bus.done_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wr_data_o}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      mem[16'h10 + i] = 16'hA000 + 16'(i) * 16'h0B0B;
      model_mem[16'h10 + i] = mem[16'h10 + i];
    end
    run_op(16'h0010, 16'h0040, 16'd4, 1'b0, '0, "copy4");
    run_op(16'h0123, 16'h0456, 16'd0, 1'b0, '0, "len0");
    run_op(16'hFFFE, 16'h0100, 16'd3, 1'b0, '0, "wrap");
    run_op(16'h0200, 16'h0202, 16'd5, 1'b0, '0, "overlap");
    run_op(16'hFFFF, 16'h0700, 16'd1, 1'b0, '0, "single");

    // Reset lands on the edge ending the second WRITE: lines 0 and 1 only, no done.
    bus.src_addr_i = 16'h0300;
    bus.dst_addr_i = 16'h0380;
    bus.len_i = 16'd4;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    bus.start_i = 1'b0;
    model_op(16'h0300, 16'h0380, 16'd4, 1'b0, '0, 2, acc, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_outs", {bus.busy_o, bus.done_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wr_data_o}, 64'h0);
    repeat (12) @(posedge clk);
    #1;
    drain("abort");

    // start_i held high: one transfer, then a second accepted only in the IDLE after DONE.
    bus.src_addr_i = 16'h0500;
    bus.dst_addr_i = 16'h0580;
    bus.len_i = 16'd2;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    model_op(16'h0500, 16'h0580, 16'd2, 1'b0, '0, 2, acc, 1'b1);
    model_op(16'h0500, 16'h0580, 16'd2, 1'b0, '0, 2, acc + 6, 1'b1);
    repeat (6) @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    drain("held_start");

`ifdef MEMCOPY_FILL_EN
    run_op(16'h0000, 16'h0020, 16'd3, 1'b1, 16'hA5A5, "fill3");
`endif

    for (int k = 0; k < 12; k++) begin
      bit f;
      f = 1'b0;
`ifdef MEMCOPY_FILL_EN
      f = ($urandom_range(0, 2) == 0);
`endif
      run_op(AW'($urandom), AW'($urandom), AW'($urandom_range(1, 12)), f, LW'($urandom), "rand");
    end

    mism = 0;
    for (int i = 0; i < (1 << AW); i++) if (mem[i] !== model_mem[i]) mism++;
    check("mem_image", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 16 and set the memory line-address width.
REQ-002 Parameter LINE_WIDTH SHALL default to 16 and set the memory data-line width.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 start_i  input  1  SHALL request an operation; sampled only in IDLE.
REQ-006 src_addr_i  input  ADDR_WIDTH  SHALL give the first source line address.
REQ-007 dst_addr_i  input  ADDR_WIDTH  SHALL give the first destination line address.
REQ-008 len_i  input  ADDR_WIDTH  SHALL give the number of lines to transfer.
REQ-009 fill_i  input  1  SHALL select fill mode when high; present only under MEMCOPY_FILL_EN.
REQ-010 fill_data_i  input  LINE_WIDTH  SHALL be the fill pattern; present only under MEMCOPY_FILL_EN.
REQ-011 busy_o  output  1  SHALL be high while in READ or WRITE.
REQ-012 done_o  output  1  SHALL pulse high for exactly one cycle (DONE state).
REQ-013 mem_addr_o  output  ADDR_WIDTH  SHALL drive the memory line address.
REQ-014 mem_rd_data_i  input  LINE_WIDTH  SHALL be the memory's asynchronous read data for mem_addr_o.
REQ-015 mem_wr_data_o  output  LINE_WIDTH  SHALL drive memory write data.
REQ-016 mem_we_o  output  1  SHALL be the memory write enable; the write commits on the clk_i edge ending the cycle.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, DONE; all outputs decoded from registered state/datapath only (Moore).
REQ-018 IDLE: start_i=1 and len_i!=0 SHALL latch src/dst/len into src_q/dst_q/rem_q and go to READ (copy) or WRITE (fill).
REQ-019 IDLE: start_i=1 and len_i=0 SHALL go directly to DONE with no memory write.
REQ-020 READ: mem_addr_o=src_q, mem_we_o=0; data_q SHALL capture mem_rd_data_i at cycle end; next state WRITE.
REQ-021 WRITE: mem_addr_o=dst_q, mem_wr_data_o=data_q (fill: fill pattern), mem_we_o=1; src_q, dst_q +1, rem_q -1.
REQ-022 WRITE exit: rem_q==1 SHALL go to DONE; otherwise READ (copy) or WRITE (fill).
REQ-023 DONE: done_o=1, mem_we_o=0; next state IDLE unconditionally.
REQ-024 Address increments SHALL wrap modulo 2^ADDR_WIDTH; len_i=2^ADDR_WIDTH-1 is the maximum transfer.
REQ-025 start_i outside IDLE (including DONE) SHALL be ignored.
REQ-026 Copy latency: done_o SHALL assert 2N+1 cycles after the accepting edge for N lines; fill: N+1 cycles.
REQ-027 Overlapping ranges SHALL be copied strictly in ascending order, line by line, without overlap protection.
REQ-028 In IDLE, mem_addr_o and mem_wr_data_o SHALL be 0 and mem_we_o SHALL be 0.

Reset
REQ-029 rst_ni=0 at an edge SHALL force IDLE and clear src_q, dst_q, rem_q, data_q to 0, regardless of state.
REQ-030 After reset: busy_o=0, done_o=0, mem_we_o=0, mem_addr_o=0, mem_wr_data_o=0; an interrupted transfer SHALL NOT resume or signal done.

Configuration
REQ-031 Macro MEMCOPY_FILL_EN defined: fill_i/fill_data_i SHALL exist, and fill_i=1 at start SHALL latch fill_data_i and skip READ.
REQ-032 Macro MEMCOPY_FILL_EN undefined: fill_i/fill_data_i SHALL be absent and every operation SHALL be a copy.

Verification
REQ-033 Preload mem[0x10..0x13]=A,B,C,D; start src=0x10 dst=0x40 len=4 -> mem[0x40..0x43]=A..D, done_o pulses once 9 cycles after the accepting edge.
REQ-034 start with len=0 -> done_o high in the next cycle, mem_we_o never asserted, busy_o stays 0.
REQ-035 Copy src=0xFFFE dst=0x0100 len=3 -> reads 0xFFFE,0xFFFF,0x0000 in order; writes 0x0100..0x0102.
REQ-036 Pulse rst_ni low during the second WRITE of a 4-line copy -> next cycle IDLE, only lines 0 and 1 written, no done_o.
REQ-037 With MEMCOPY_FILL_EN: fill_i=1 fill_data=0xA5A5 dst=0x20 len=3 -> mem[0x20..0x22]=0xA5A5, done_o 4 cycles after accept.
REQ-038 Assert start_i continuously during a copy -> exactly one transfer; a new one is accepted only in the IDLE cycle after DONE.
